// File: rtl/ysyx_22041071_ifu_axi_rd.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_ifu_axi_rd
//
// Instruction-fetch AXI4 read master feeding the IF stage. It accepts one
// fetch PC, issues a single-beat 64-bit read for the 8-byte-aligned address,
// and presents the returned beat, its response and the fetch PC to IF. IF
// picks the 32-bit half with pc_out[2]. Only one transaction is ever
// outstanding. A flush kills any in-flight fetch: the AXI transaction still
// completes on the bus, but its beat is dropped.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   pc_valid/pc/pc_ready       fetch request from the PC generator
//   flush                      redirect, kills the current fetch
//   ar_*                       AXI read-address channel (master side)
//   r_*                        AXI read-data channel (master side)
//   cpu_r_valid/cpu_r_data/
//   cpu_resp/pc_out/ready2     fetched beat handed to IF
// ---------------------------------------------------------------------------
module ysyx_22041071_ifu_axi_rd #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int RESP_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   // fetch request
   input  logic              pc_valid,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_ready,
   input  logic              flush,
   // AXI read-address channel
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [ID_W-1:0]   ar_id,
   output logic [7:0]        ar_len,
   output logic [2:0]        ar_size,
   output logic [1:0]        ar_burst,
   output logic [2:0]        ar_prot,
   // AXI read-data channel
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [DATA_W-1:0] r_data,
   input  logic [RESP_W-1:0] r_resp,
   input  logic              r_last,
   // fetched beat to IF
   output logic              cpu_r_valid,
   output logic [DATA_W-1:0] cpu_r_data,
   output logic [RESP_W-1:0] cpu_resp,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              ready2
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   state_e            state_q;
   logic              kill_q;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] data_q;
   logic [RESP_W-1:0] resp_q;

   logic req_fire;
   logic beat_done;

   // A request is only taken when no redirect is pending in the same cycle.
   assign req_fire  = pc_valid & pc_ready & ~flush;
   assign beat_done = r_valid & r_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         kill_q  <= 1'b0;
         pc_q    <= '0;
         data_q  <= '0;
         resp_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               kill_q <= 1'b0;
               if (req_fire) begin
                  pc_q    <= pc;
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: begin
               // AR stays up through a flush; the kill flag drops the beat later.
               if (flush) kill_q <= 1'b1;
               if (ar_ready) state_q <= S_DATA;
            end
            S_DATA: begin
               if (beat_done) begin
                  kill_q <= 1'b0;
                  // A flush arriving with the last beat discards it as well.
                  if (kill_q | flush) begin
                     state_q <= S_IDLE;
                  end else begin
                     data_q  <= r_data;
                     resp_q  <= r_resp;
                     state_q <= S_HOLD;
                  end
               end else if (flush) begin
                  kill_q <= 1'b1;
               end
            end
            S_HOLD: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else if (ready2) begin
                  // Back-to-back: the next PC can be taken as the beat leaves.
                  if (req_fire) begin
                     pc_q    <= pc;
                     state_q <= S_ADDR;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      pc_ready = 1'b0;
      case (state_q)
         S_IDLE:  pc_ready = 1'b1;
         S_HOLD:  pc_ready = ready2;
         default: pc_ready = 1'b0;
      endcase
   end

   assign ar_valid    = (state_q == S_ADDR);
   assign r_ready     = (state_q == S_DATA);
   assign cpu_r_valid = (state_q == S_HOLD);

   assign ar_addr  = {pc_q[ADDR_W-1:3], 3'b000};
   assign ar_id    = '0;
   assign ar_len   = 8'd0;
   assign ar_size  = 3'b011;
   assign ar_burst = 2'b01;
   assign ar_prot  = 3'b100;

   assign cpu_r_data = data_q;
   assign cpu_resp   = resp_q;
   assign pc_out     = pc_q;

endmodule

// File: tb/tb_ysyx_22041071_ifu_axi_rd.sv
module tb_ysyx_22041071_ifu_axi_rd;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_valid;
   logic [63:0] pc;
   logic        pc_ready;
   logic        flush;
   logic        ar_valid;
   logic        ar_ready;
   logic [63:0] ar_addr;
   logic [3:0]  ar_id;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic [2:0]  ar_prot;
   logic        r_valid;
   logic        r_ready;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        cpu_r_valid;
   logic [63:0] cpu_r_data;
   logic [1:0]  cpu_resp;
   logic [63:0] pc_out;
   logic        ready2;

   int checks   = 0;
   int failures = 0;
   int ar_hs    = 0;

   always #5 clk = ~clk;

   ysyx_22041071_ifu_axi_rd dut (
      .clk(clk), .reset(reset),
      .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready), .flush(flush),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_prot(ar_prot),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
      .cpu_r_valid(cpu_r_valid), .cpu_r_data(cpu_r_data), .cpu_resp(cpu_resp),
      .pc_out(pc_out), .ready2(ready2)
   );

   // AR handshakes seen on the bus, to catch duplicate requests.
   always @(posedge clk) if (!reset && ar_valid && ar_ready) ar_hs = ar_hs + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      pc_valid = 0; pc = '0; flush = 0; ar_ready = 0;
      r_valid = 0; r_data = '0; r_resp = '0; r_last = 0; ready2 = 0;
   endtask

   // From IDLE: issue pc, take AR immediately, end up in DATA.
   task automatic go_to_data(input logic [63:0] p);
      pc_valid = 1; pc = p; ar_ready = 1;
      tick();
      pc_valid = 0; pc = '0;
      tick();
      ar_ready = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      tick(); tick();
      checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL reset_pc_ready got=%0h exp=1", pc_ready); end
      checks++; if ({ar_valid, r_ready, cpu_r_valid} !== 3'b000) begin failures++; $display("FAIL reset_valids got=%b exp=000", {ar_valid, r_ready, cpu_r_valid}); end
      checks++; if ({ar_addr, pc_out, cpu_r_data} !== 192'd0) begin failures++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0", ar_addr, pc_out, cpu_r_data); end
      checks++; if (cpu_resp !== 2'b00) begin failures++; $display("FAIL reset_resp got=%0h exp=0", cpu_resp); end
      checks++; if ({ar_id, ar_len, ar_size, ar_burst, ar_prot} !== {4'h0, 8'h00, 3'b011, 2'b01, 3'b100}) begin
         failures++; $display("FAIL ar_const got=%0h/%0h/%0h/%0h/%0h exp=0/0/3/1/4", ar_id, ar_len, ar_size, ar_burst, ar_prot);
      end
      reset = 0;
      tick();
   endtask

   task automatic test_basic_fetch();
      int hs0;
      hs0 = ar_hs;
      pc_valid = 1; pc = 64'h8000_0004; ar_ready = 1;
      tick(); // N+1
      pc_valid = 0;
      checks++; if (ar_valid !== 1'b1 || ar_addr !== 64'h8000_0000) begin failures++; $display("FAIL basic_ar got=%b/%0h exp=1/80000000", ar_valid, ar_addr); end
      checks++; if (pc_ready !== 1'b0) begin failures++; $display("FAIL basic_pc_ready_addr got=%b exp=0", pc_ready); end
      tick(); // N+2
      ar_ready = 0;
      checks++; if ({ar_valid, r_ready, cpu_r_valid} !== 3'b010) begin failures++; $display("FAIL basic_data_state got=%b exp=010", {ar_valid, r_ready, cpu_r_valid}); end
      r_valid = 1; r_last = 1; r_data = 64'h1234_5678_9abc_def0; r_resp = 2'b00;
      tick(); // N+3
      r_valid = 0; r_last = 0; r_data = '0;
      checks++; if (cpu_r_valid !== 1'b1 || cpu_r_data !== 64'h1234_5678_9abc_def0) begin failures++; $display("FAIL basic_beat got=%b/%0h exp=1/123456789abcdef0", cpu_r_valid, cpu_r_data); end
      checks++; if (pc_out !== 64'h8000_0004 || cpu_resp !== 2'b00) begin failures++; $display("FAIL basic_pc_resp got=%0h/%0h exp=80000004/0", pc_out, cpu_resp); end
      checks++; if (r_ready !== 1'b0) begin failures++; $display("FAIL basic_r_ready_hold got=%b exp=0", r_ready); end
      ready2 = 1;
      tick();
      ready2 = 0;
      checks++; if (cpu_r_valid !== 1'b0 || pc_ready !== 1'b1) begin failures++; $display("FAIL basic_release got=%b/%b exp=0/1", cpu_r_valid, pc_ready); end
      checks++; if (ar_hs - hs0 !== 1) begin failures++; $display("FAIL basic_ar_count got=%0d exp=1", ar_hs - hs0); end
   endtask

   task automatic test_ar_stall_and_hold();
      int hs0;
      int bad;
      hs0 = ar_hs;
      pc_valid = 1; pc = 64'h1000_001c; ar_ready = 0;
      tick();
      pc_valid = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (ar_valid !== 1'b1 || ar_addr !== 64'h1000_0018) bad++;
         tick();
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL ar_stall_stable got=%0d bad cycles exp=0", bad); end
      ar_ready = 1;
      checks++; if (ar_valid !== 1'b1) begin failures++; $display("FAIL ar_stall_still_valid got=%b exp=1", ar_valid); end
      tick();
      ar_ready = 0;
      checks++; if (ar_valid !== 1'b0 || r_ready !== 1'b1) begin failures++; $display("FAIL ar_stall_to_data got=%b/%b exp=0/1", ar_valid, r_ready); end
      checks++; if (ar_hs - hs0 !== 1) begin failures++; $display("FAIL ar_stall_dup got=%0d exp=1", ar_hs - hs0); end
      // error response forwarded with the data
      r_valid = 1; r_last = 1; r_data = 64'hdead_beef_cafe_f00d; r_resp = 2'b10;
      tick();
      r_valid = 0; r_last = 0; r_data = '0; r_resp = '0;
      checks++; if (cpu_r_valid !== 1'b1 || cpu_resp !== 2'b10 || cpu_r_data !== 64'hdead_beef_cafe_f00d) begin
         failures++; $display("FAIL err_resp got=%b/%0h/%0h exp=1/2/deadbeefcafef00d", cpu_r_valid, cpu_resp, cpu_r_data);
      end
      // IF stalls for 4 cycles while the next PC waits
      pc_valid = 1; pc = 64'h2000_0000;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (cpu_r_valid !== 1'b1 || cpu_r_data !== 64'hdead_beef_cafe_f00d || pc_out !== 64'h1000_001c || pc_ready !== 1'b0 || ar_valid !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
      ready2 = 1;
      #1;
      checks++; if (pc_ready !== 1'b1) begin failures++; $display("FAIL hold_pc_ready got=%b exp=1", pc_ready); end
      tick();
      ready2 = 0; pc_valid = 0;
      checks++; if (ar_valid !== 1'b1 || ar_addr !== 64'h2000_0000 || cpu_r_valid !== 1'b0) begin
         failures++; $display("FAIL back_to_back got=%b/%0h/%b exp=1/20000000/0", ar_valid, ar_addr, cpu_r_valid);
      end
      // finish this fetch normally
      ar_ready = 1; tick(); ar_ready = 0;
      r_valid = 1; r_last = 1; r_data = 64'h1; tick();
      r_valid = 0; r_last = 0; ready2 = 1; tick(); ready2 = 0;
   endtask

   task automatic test_flush_data();
      int bad;
      go_to_data(64'h3000_0008);
      flush = 1;
      tick();
      flush = 0;
      bad = 0;
      // a non-last beat is ignored
      r_valid = 1; r_last = 0; r_data = 64'h5555;
      if (cpu_r_valid !== 1'b0) bad++;
      tick();
      checks++; if (r_ready !== 1'b1) begin failures++; $display("FAIL nonlast_stays got=%b exp=1", r_ready); end
      r_last = 1;
      if (cpu_r_valid !== 1'b0) bad++;
      tick();
      r_valid = 0; r_last = 0; r_data = '0;
      checks++; if (cpu_r_valid !== 1'b0 || r_ready !== 1'b0 || pc_ready !== 1'b1 || bad !== 0) begin
         failures++; $display("FAIL flush_data got=%b/%b/%b bad=%0d exp=0/0/1 bad=0", cpu_r_valid, r_ready, pc_ready, bad);
      end
      tick();
      checks++; if (cpu_r_valid !== 1'b0) begin failures++; $display("FAIL flush_data_late got=%b exp=0", cpu_r_valid); end
   endtask

   task automatic test_flush_corners();
      // flush together with the last beat
      go_to_data(64'h4000_0000);
      flush = 1; r_valid = 1; r_last = 1; r_data = 64'h77;
      tick();
      flush = 0; r_valid = 0; r_last = 0;
      checks++; if (cpu_r_valid !== 1'b0 || pc_ready !== 1'b1) begin failures++; $display("FAIL flush_rlast got=%b/%b exp=0/1", cpu_r_valid, pc_ready); end
      // flush in ADDR: AR still completes, beat dropped
      pc_valid = 1; pc = 64'h4100_0000; ar_ready = 0;
      tick();
      pc_valid = 0; flush = 1;
      tick();
      flush = 0;
      checks++; if (ar_valid !== 1'b1) begin failures++; $display("FAIL flush_addr_ar got=%b exp=1", ar_valid); end
      ar_ready = 1; tick(); ar_ready = 0;
      r_valid = 1; r_last = 1; tick(); r_valid = 0; r_last = 0;
      checks++; if (cpu_r_valid !== 1'b0 || pc_ready !== 1'b1) begin failures++; $display("FAIL flush_addr got=%b/%b exp=0/1", cpu_r_valid, pc_ready); end
      // the kill does not leak into the next fetch
      go_to_data(64'h4200_0004);
      r_valid = 1; r_last = 1; r_data = 64'habcd; tick(); r_valid = 0; r_last = 0;
      checks++; if (cpu_r_valid !== 1'b1 || cpu_r_data !== 64'habcd) begin failures++; $display("FAIL kill_cleared got=%b/%0h exp=1/abcd", cpu_r_valid, cpu_r_data); end
      // flush in HOLD
      flush = 1;
      tick();
      flush = 0;
      checks++; if (cpu_r_valid !== 1'b0 || pc_ready !== 1'b1 || ar_valid !== 1'b0) begin failures++; $display("FAIL flush_hold got=%b/%b/%b exp=0/1/0", cpu_r_valid, pc_ready, ar_valid); end
      // flush in IDLE blocks the same-cycle request
      pc_valid = 1; pc = 64'h4300_0000; flush = 1;
      tick();
      pc_valid = 0; flush = 0;
      checks++; if (ar_valid !== 1'b0 || pc_ready !== 1'b1) begin failures++; $display("FAIL flush_idle got=%b/%b exp=0/1", ar_valid, pc_ready); end
   endtask

   task automatic test_reset_in_data();
      go_to_data(64'h5000_000c);
      reset = 1;
      tick();
      reset = 0;
      checks++; if ({ar_valid, r_ready, cpu_r_valid} !== 3'b000 || pc_ready !== 1'b1) begin
         failures++; $display("FAIL reset_data_ctrl got=%b pc_ready=%b exp=000 1", {ar_valid, r_ready, cpu_r_valid}, pc_ready);
      end
      checks++; if (ar_addr !== 64'd0 || pc_out !== 64'd0 || cpu_r_data !== 64'd0 || cpu_resp !== 2'd0) begin
         failures++; $display("FAIL reset_data_regs got=%0h/%0h/%0h/%0h exp=0", ar_addr, pc_out, cpu_r_data, cpu_resp);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_ar_stall_and_hold();
      test_flush_data();
      test_flush_corners();
      test_reset_in_data();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
